// File: rtl/row_avg_sequencer.sv
// Streaming row-average engine: buffers one row and emits floor((prev + cur) / 2) per pixel
// for every row after the first, using a valid/ready handshake on both sides.
module row_avg_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned ROWS  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_o,
    output logic             valid_o,
    input  logic             out_ready_i,
    output logic             frame_done_o
);

    localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);

    typedef enum logic [1:0] {
        StFill,
        StStream,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             frame_done_q, frame_done_d;

    logic [WIDTH-1:0] linebuf_q [COLS];
    logic             lb_we;
    logic             in_ready;
    logic             accept;
    logic             take;
    logic [WIDTH:0]   sum;
    logic             col_last;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StFill:   in_ready = 1'b1;
            // A pending result may only be replaced if it is consumed in the same cycle.
            StStream: in_ready = !valid_q || out_ready_i;
            StDrain:  in_ready = 1'b0;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid_i && in_ready;
    assign take     = valid_q && out_ready_i;
    assign col_last = (col_q == ColLast);
    // One extra bit keeps the sum exact before halving.
    assign sum      = {1'b0, linebuf_q[col_q]} + {1'b0, data_i};

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        out_d        = out_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (take) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    lb_we = 1'b1;
                    if (col_last) begin
                        col_d   = '0;
                        row_d   = RowW'(1);
                        state_d = StStream;
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
            StStream: begin
                if (accept) begin
                    lb_we   = 1'b1;
                    out_d   = WIDTH'(sum >> 1);
                    valid_d = 1'b1;
                    if (col_last) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            row_d   = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + RowW'(1);
                        end
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
            StDrain: begin
                if (take) begin
                    frame_done_d = 1'b1;
                    col_d        = '0;
                    row_d        = '0;
                    state_d      = StFill;
                end
            end
            default: begin
                state_d = StFill;
                col_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFill;
            col_q        <= '0;
            row_q        <= '0;
            out_q        <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Not reset: every frame rewrites the whole row before it is read.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[col_q] <= data_i;
        end
    end

    assign in_ready_o   = in_ready;
    assign out_o        = out_q;
    assign valid_o      = valid_q;
    assign frame_done_o = frame_done_q;

endmodule
